control_microsequencer: RTL and testbench

//  Next-state engine for the microprogrammed control unit. Holds the 7-bit state register that

---
 rtl/control_microsequencer_pkg.sv | 32 +++
 rtl/control_microsequencer_if.sv | 29 ++
 rtl/control_microsequencer_opcode_dispatch_rom.sv | 27 ++
 rtl/control_microsequencer.sv | 108 ++++++++++
 tb/tb_control_microsequencer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/control_microsequencer_pkg.sv
// Shared encodings for the microsequencer: sequencing selects, condition sources,
// instruction opcodes and the microstates they dispatch to.
package ctrl_pkg;

  typedef enum logic [1:0] {
    NS_DISPATCH = 2'b00,
    NS_JUMP     = 2'b01,
    NS_INC      = 2'b10,
    NS_COND     = 2'b11
  } ns_sel_e;

  typedef enum logic [1:0] {
    CS_MOC    = 2'b00,
    CS_BRANCH = 2'b01,
    CS_ONE    = 2'b10,
    CS_ZERO   = 2'b11
  } cond_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [6:0] S_RESET = 7'd0;
  localparam logic [6:0] S_RTYPE = 7'd10;
  localparam logic [6:0] S_ADDIU = 7'd11;
  localparam logic [6:0] S_LW    = 7'd4;
  localparam logic [6:0] S_SW    = 7'd7;
  localparam logic [6:0] S_BEQ   = 7'd9;

endpackage

// File: rtl/control_microsequencer_if.sv
// Microstore sequencing fields, IR/condition inputs and sequencer status outputs.
// No handshake: every field is sampled each rising edge unless hold is high.
interface control_microsequencer_if #(
  parameter int STATE_W  = 7,
  parameter int OPCODE_W = 6
);
  logic [1:0]          ns_sel;
  logic [STATE_W-1:0]  cr_addr;
  logic [1:0]          cond_sel;
  logic                inv;
  logic [OPCODE_W-1:0] opcode;
  logic                moc;
  logic                branch_true;
  logic                hold;
  logic [STATE_W-1:0]  state;
  logic                moc_wait;
  logic                bus_error;
  logic                illegal_trap;

  modport master (
    output ns_sel, cr_addr, cond_sel, inv, opcode, moc, branch_true, hold,
    input  state, moc_wait, bus_error, illegal_trap
  );

  modport slave (
    input  ns_sel, cr_addr, cond_sel, inv, opcode, moc, branch_true, hold,
    output state, moc_wait, bus_error, illegal_trap
  );
endinterface

// File: rtl/control_microsequencer_opcode_dispatch_rom.sv
// Combinational opcode decode: maps an IR opcode to its first microstate.
// Unknown opcodes return S_RESET and raise illegal_o.
module opcode_dispatch_rom
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 7
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [STATE_W-1:0]  target_o,
  output logic                illegal_o
);

  always_comb begin
    target_o  = STATE_W'(S_RESET);
    illegal_o = 1'b0;
    case (opcode_i)
      OPCODE_W'(OP_RTYPE): target_o = STATE_W'(S_RTYPE);
      OPCODE_W'(OP_ADDIU): target_o = STATE_W'(S_ADDIU);
      OPCODE_W'(OP_LW):    target_o = STATE_W'(S_LW);
      OPCODE_W'(OP_SW):    target_o = STATE_W'(S_SW);
      OPCODE_W'(OP_BEQ):   target_o = STATE_W'(S_BEQ);
      default:             illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_microsequencer.sv
// Next-state engine of the microprogrammed control unit: selects the next microstore
// address each cycle, with an MOC wait watchdog and illegal opcode/state trapping.
module control_microsequencer
  import ctrl_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int OPCODE_W    = 6,
  parameter int NUM_STATES  = 12,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  control_microsequencer_if.slave bus
);

  localparam int WDOG_W = ($clog2(MOC_TIMEOUT + 1) > 4) ? $clog2(MOC_TIMEOUT + 1) : 4;

  logic [STATE_W-1:0] state_q, state_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               bus_error_q, bus_error_d;
  logic               illegal_q, illegal_d;

  logic               cond_src, cond;
  logic [STATE_W-1:0] state_inc, sel_next, rom_target;
  logic               rom_illegal, trap, wait_cyc, timeout;

  opcode_dispatch_rom #(
    .OPCODE_W (OPCODE_W),
    .STATE_W  (STATE_W)
  ) u_rom (
    .opcode_i  (bus.opcode),
    .target_o  (rom_target),
    .illegal_o (rom_illegal)
  );

  always_comb begin
    cond_src = 1'b0;
    case (cond_sel_e'(bus.cond_sel))
      CS_MOC:    cond_src = bus.moc;
      CS_BRANCH: cond_src = bus.branch_true;
      CS_ONE:    cond_src = 1'b1;
      CS_ZERO:   cond_src = 1'b0;
      default:   cond_src = 1'b0;
    endcase
    cond = cond_src ^ bus.inv;
  end

  assign state_inc = state_q + STATE_W'(1);

  always_comb begin
    sel_next = state_inc;
    case (ns_sel_e'(bus.ns_sel))
      NS_DISPATCH: sel_next = rom_target;
      NS_JUMP:     sel_next = bus.cr_addr;
      NS_INC:      sel_next = state_inc;
      NS_COND:     sel_next = cond ? bus.cr_addr : state_inc;
      default:     sel_next = state_inc;
    endcase
  end

  // An undecodable opcode already lands on state 0, so it only contributes the trap flag.
  assign trap = ((ns_sel_e'(bus.ns_sel) == NS_DISPATCH) && rom_illegal) ||
                (sel_next >= STATE_W'(NUM_STATES));

  assign wait_cyc = (ns_sel_e'(bus.ns_sel) == NS_COND) &&
                    (cond_sel_e'(bus.cond_sel) == CS_MOC) &&
                    (bus.cr_addr == state_q) && cond;
  assign timeout  = wait_cyc && (wdog_q == WDOG_W'(MOC_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    bus_error_d = 1'b0;
    illegal_d   = 1'b0;
    if (bus.hold) begin
      state_d = state_q;
      wdog_d  = wdog_q;
    end else if (timeout) begin
      state_d     = STATE_W'(S_RESET);
      wdog_d      = '0;
      bus_error_d = 1'b1;
    end else begin
      state_d   = trap ? STATE_W'(S_RESET) : sel_next;
      illegal_d = trap;
      wdog_d    = wait_cyc ? wdog_q + WDOG_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STATE_W'(S_RESET);
      wdog_q      <= '0;
      bus_error_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      bus_error_q <= bus_error_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.moc_wait     = wait_cyc;
  assign bus.bus_error    = bus_error_q;
  assign bus.illegal_trap = illegal_q;

endmodule

// File: tb/tb_control_microsequencer.sv
// Directed bench for control_microsequencer: each step pushes the expected
// {state, bus_error, illegal_trap} and pops it after the clock edge.
module tb_control_microsequencer;
  import ctrl_pkg::*;

  localparam int W = 9;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  control_microsequencer_if #(.STATE_W(7), .OPCODE_W(6)) ms_if ();

  control_microsequencer #(
    .STATE_W(7), .OPCODE_W(6), .NUM_STATES(12), .MOC_TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ms_if)
  );

  task automatic check_out(input string tag);
    logic [W-1:0] exp, got;
    got = {ms_if.state, ms_if.bus_error, ms_if.illegal_trap};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, got %h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: state/bus_error/illegal got %0d/%b/%b expected %0d/%b/%b",
               tag, got[8:2], got[1], got[0], exp[8:2], exp[1], exp[0]);
      end
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input string tag, input logic [1:0] ns, input logic [6:0] cr,
                      input logic [1:0] cs, input logic inv, input logic [5:0] op,
                      input logic moc, input logic bt, input logic hold,
                      input logic [6:0] es, input logic ebe, input logic eit,
                      input logic chk_w, input logic ew);
    ms_if.ns_sel = ns; ms_if.cr_addr = cr; ms_if.cond_sel = cs; ms_if.inv = inv;
    ms_if.opcode = op; ms_if.moc = moc; ms_if.branch_true = bt; ms_if.hold = hold;
    #1;
    if (chk_w) begin
      checks++;
      assert (ms_if.moc_wait === ew) else begin
        errors++;
        $error("FAIL %s moc_wait: got %b expected %b", tag, ms_if.moc_wait, ew);
      end
    end
    exp_q.push_back({es, ebe, eit});
    @(posedge clk); #1;
    check_out(tag);
  endtask

  task automatic simple(input string tag, input logic [1:0] ns, input logic [6:0] cr,
                        input logic [5:0] op, input logic [6:0] es, input logic eit);
    step(tag, ns, cr, CS_ZERO, 1'b0, op, 1'b0, 1'b0, 1'b0, es, 1'b0, eit, 1'b0, 1'b0);
  endtask

  // COND self-loop on moc with inv=1: waits while moc stays low.
  task automatic wait_step(input string tag, input logic [6:0] cr, input logic moc,
                           input logic hold, input logic [6:0] es, input logic ebe,
                           input logic chk_w, input logic ew);
    step(tag, NS_COND, cr, CS_MOC, 1'b1, 6'h00, moc, 1'b0, hold, es, ebe, 1'b0, chk_w, ew);
  endtask

  task automatic reset_cycle(input string tag);
    reset = 1'b1;
    ms_if.ns_sel = 2'($urandom_range(0, 3)); ms_if.cr_addr = 7'($urandom_range(0, 127));
    ms_if.cond_sel = 2'($urandom_range(0, 3)); ms_if.inv = 1'($urandom_range(0, 1));
    ms_if.opcode = 6'($urandom_range(0, 63)); ms_if.moc = 1'($urandom_range(0, 1));
    ms_if.branch_true = 1'($urandom_range(0, 1)); ms_if.hold = 1'($urandom_range(0, 1));
    exp_q.push_back({7'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check_out(tag);
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ops[4];
    logic [6:0] tgts[4];
    ops  = '{OP_RTYPE, OP_ADDIU, OP_SW, OP_BEQ};
    tgts = '{S_RTYPE, S_ADDIU, S_SW, S_BEQ};
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset and increment
    reset_cycle("reset0");
    reset_cycle("reset1");
    simple("inc1", NS_INC, 7'd0, 6'h00, 7'd1, 1'b0);
    simple("inc2", NS_INC, 7'd0, 6'h00, 7'd2, 1'b0);

    // Dispatch
    simple("jump1", NS_JUMP, 7'd1, 6'h00, 7'd1, 1'b0);
    simple("disp_lw", NS_DISPATCH, 7'd0, OP_LW, 7'd4, 1'b0);
    simple("disp_bad", NS_DISPATCH, 7'd0, 6'h3F, 7'd0, 1'b1);
    step("hold_clr", NS_DISPATCH, 7'd0, CS_ZERO, 1'b0, 6'h3F, 1'b0, 1'b0, 1'b1,
         7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    simple("after_bad", NS_INC, 7'd0, 6'h00, 7'd1, 1'b0);
    for (int i = 0; i < 4; i++) simple("disp_tbl", NS_DISPATCH, 7'd0, ops[i], tgts[i], 1'b0);

    // Conditional branch
    simple("jump1b", NS_JUMP, 7'd1, 6'h00, 7'd1, 1'b0);
    step("cond_bt", NS_COND, 7'd0, CS_BRANCH, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0,
         7'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("cond_bt_inv", NS_COND, 7'd6, CS_BRANCH, 1'b1, 6'h00, 1'b0, 1'b1, 1'b0,
         7'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("cond_one", NS_COND, 7'd3, CS_ONE, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0,
         7'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("cond_zero", NS_COND, 7'd8, CS_ZERO, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0,
         7'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // MOC wait completes
    simple("jump5", NS_JUMP, 7'd5, 6'h00, 7'd5, 1'b0);
    for (int i = 0; i < 3; i++) wait_step("moc_wait", 7'd5, 1'b0, 1'b0, 7'd5, 1'b0, 1'b1, 1'b1);
    wait_step("moc_done", 7'd5, 1'b1, 1'b0, 7'd6, 1'b0, 1'b1, 1'b0);

    // Watchdog expiry after 15 wait cycles
    simple("jump5_wd", NS_JUMP, 7'd5, 6'h00, 7'd5, 1'b0);
    for (int i = 0; i < 14; i++) wait_step("wd_wait", 7'd5, 1'b0, 1'b0, 7'd5, 1'b0, 1'b1, 1'b1);
    wait_step("wd_expire", 7'd5, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b1);
    simple("wd_pulse_end", NS_INC, 7'd0, 6'h00, 7'd1, 1'b0);

    // Watchdog with a 4-cycle hold in the middle
    simple("jump5_hd", NS_JUMP, 7'd5, 6'h00, 7'd5, 1'b0);
    for (int i = 0; i < 7; i++) wait_step("hd_wait_a", 7'd5, 1'b0, 1'b0, 7'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) wait_step("hd_hold", 7'd5, 1'b0, 1'b1, 7'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) wait_step("hd_wait_b", 7'd5, 1'b0, 1'b0, 7'd5, 1'b0, 1'b0, 1'b0);
    wait_step("hd_expire", 7'd5, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);

    // Range check
    simple("jump11", NS_JUMP, 7'd11, 6'h00, 7'd11, 1'b0);
    simple("inc_wrap", NS_INC, 7'd0, 6'h00, 7'd0, 1'b1);
    simple("jump12", NS_JUMP, 7'd12, 6'h00, 7'd0, 1'b1);
    simple("jump127", NS_JUMP, 7'd127, 6'h00, 7'd0, 1'b1);

    // Reset mid-wait clears the watchdog
    simple("jump5_rst", NS_JUMP, 7'd5, 6'h00, 7'd5, 1'b0);
    for (int i = 0; i < 10; i++) wait_step("rst_wait", 7'd5, 1'b0, 1'b0, 7'd5, 1'b0, 1'b0, 1'b0);
    reset_cycle("rst_mid_wait");
    for (int i = 0; i < 14; i++) wait_step("post_rst_wait", 7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
    wait_step("post_rst_expire", 7'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
